// File: rtl/orion_sched_pkg.sv
// Shared types and helpers for the Orion token scheduler.
// Holds the scheduler state encoding and the round-robin pick function.
package orion_sched_pkg;

  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR,
    DRAIN
  } sched_state_t;

  // First set bit at or after ptr, wrapping. Unused upper bits must be zero,
  // which makes the mod-16 wrap equivalent to a mod-NUM_REQ wrap.
  function automatic logic [MAX_ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [MAX_ID_W-1:0] ptr);
    logic [MAX_ID_W-1:0] pick;
    logic [MAX_ID_W-1:0] idx;
    logic                found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      idx = ptr + MAX_ID_W'(i);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/orion_sync2.sv
// Two-flop synchronizer for a single asynchronous level or transition signal.
// Reset value is a parameter so it can match the phase of the far side.
module orion_sync2 #(
  parameter logic P_INIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic asyncIn,
  output logic syncOut
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta    <= P_INIT;
      syncOut <= P_INIT;
    end else begin
      meta    <= asyncIn;
      syncOut <= meta;
    end
  end

endmodule

// File: rtl/orion_token_sched.sv
// Round-robin scheduler sharing one two-phase async handshake channel among
// NUM_REQ clocked requesters, with a per-token cycle budget and error recovery.
module orion_token_sched
  import orion_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  logic        P_INIT  = 1'b0,
  parameter  int unsigned TIMEOUT = 1024,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_grant,
  output logic [NUM_REQ-1:0] req_done,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               err,
  input  logic               err_clr,
  output logic               out_req,
  input  logic               out_ack
);

  localparam bit                TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [ID_W-1:0]   ID_LAST    = ID_W'(NUM_REQ - 1);

  sched_state_t     state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ack_s2;
  logic             ackMatch;
  logic             anyValid;
  logic [ID_W-1:0]  pickId;

  orion_sync2 #(.P_INIT(P_INIT)) uAckSync (
    .clk     (clk),
    .reset_n (reset_n),
    .asyncIn (out_ack),
    .syncOut (ack_s2)
  );

  assign ackMatch = (ack_s2 == out_req);
  assign anyValid = |req_valid;
  assign pickId   = ID_W'(rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(rr_ptr)));

  // Scheduler FSM; grant/done are one-cycle pulses cleared every cycle by default.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      out_req   <= P_INIT;
      req_grant <= '0;
      req_done  <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      req_grant <= '0;
      req_done  <= '0;
      case (state)
        IDLE: begin
          if (anyValid) begin
            state             <= ISSUE;
            grant_id          <= pickId;
            req_grant[pickId] <= 1'b1;
            busy              <= 1'b1;
          end
        end
        ISSUE: begin
          state   <= WAIT;
          out_req <= ~out_req;
          cnt     <= '0;
        end
        WAIT: begin
          if (ackMatch) begin
            state              <= DONE;
            req_done[grant_id] <= 1'b1;
          end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          rr_ptr <= (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
        end
        ERR: begin
          if (err_clr) begin
            state <= DRAIN;
            err   <= 1'b0;
          end
        end
        // Absorb the abandoned token's late ack before accepting new work.
        DRAIN: begin
          if (ackMatch) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orion_token_sched.sv
// Scoreboard bench for orion_token_sched: a round-robin reference model queues
// expected grants/dones, a monitor pops them as the DUT pulses its outputs.
module tb_orion_token_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] reqValid, reqGrant, reqDone;
  logic [1:0] grantId;
  logic       busy, err, errClr, outReq, outAck;
  logic [3:0] reqValid1, reqGrant1, reqDone1;
  logic [1:0] grantId1;
  logic       busy1, err1, errClr1, outReq1, outAck1;

  int checks = 0;
  int errors = 0;
  int expGrantQ[$];
  int expDoneQ[$];
  int ptrModel;
  bit ackEnable;
  int ackDelay;
  bit outstanding;

  orion_token_sched #(.NUM_REQ(4), .P_INIT(1'b0), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(reqValid), .req_grant(reqGrant),
    .req_done(reqDone), .grant_id(grantId), .busy(busy), .err(err),
    .err_clr(errClr), .out_req(outReq), .out_ack(outAck)
  );

  orion_token_sched #(.NUM_REQ(4), .P_INIT(1'b1), .TIMEOUT(8), .CNT_W(16)) dutP1 (
    .clk(clk), .reset_n(reset_n), .req_valid(reqValid1), .req_grant(reqGrant1),
    .req_done(reqDone1), .grant_id(grantId1), .busy(busy1), .err(err1),
    .err_clr(errClr1), .out_req(outReq1), .out_ack(outAck1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] oneHot(input int id);
    logic [3:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Reference: requesters drop after being served, so one round serves every
  // set bit once in circular order from the pointer; pointer ends after the last.
  task automatic modelRound(input logic [3:0] pattern);
    int last;
    last = -1;
    for (int k = 0; k < 4; k++) begin
      int id;
      id = (ptrModel + k) % 4;
      if (pattern[id]) begin
        expGrantQ.push_back(id);
        expDoneQ.push_back(id);
        last = id;
      end
    end
    if (last >= 0) ptrModel = (last + 1) % 4;
  endtask

  // Async channel: echoes out_req onto out_ack after ackDelay negedges.
  task automatic responder();
    int waited;
    waited = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        outAck = 1'b0;
        waited = 0;
      end else if (ackEnable && (outAck != outReq)) begin
        if (waited >= ackDelay) begin
          outAck = outReq;
          waited = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (!reset_n || !busy) begin
        outstanding = 1'b0;
      end else begin
        if (reqGrant != '0) begin
          if (expGrantQ.size() == 0) begin
            check("unexpected_grant", 32'(reqGrant), 32'd0);
          end else begin
            e = expGrantQ.pop_front();
            check("grant_vec", 32'({outstanding, reqGrant}), 32'({1'b0, oneHot(e)}));
            check("grant_id", 32'(grantId), 32'(e));
          end
          outstanding = 1'b1;
        end
        if (reqDone != '0) begin
          if (expDoneQ.size() == 0) begin
            check("unexpected_done", 32'(reqDone), 32'd0);
          end else begin
            e = expDoneQ.pop_front();
            check("done_vec", 32'({outstanding, reqDone}), 32'({1'b1, oneHot(e)}));
          end
          outstanding = 1'b0;
        end
      end
    end
  endtask

  task automatic serve(input string name, input int budget);
    bit fin;
    fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk);
      if (reqGrant != '0) begin
        reqValid = reqValid & ~reqGrant;
        ackDelay = int'($urandom_range(0, 4));
      end
      if (reqValid == '0 && !busy && expGrantQ.size() == 0 && expDoneQ.size() == 0) fin = 1'b1;
    end
    check(name, 32'(fin), 32'd1);
    if (!fin) begin
      reqValid = '0;
      expGrantQ.delete();
      expDoneQ.delete();
    end
  endtask

  task automatic waitGrant(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (reqGrant != '0) begin
        seen     = 1'b1;
        reqValid = reqValid & ~reqGrant;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    bit         seen;
    int         grants;
    logic [3:0] pattern;
    reset_n   = 1'b0;
    reqValid  = '0;
    errClr    = 1'b0;
    outAck    = 1'b0;
    reqValid1 = '0;
    errClr1   = 1'b0;
    outAck1   = 1'b1;
    ackEnable = 1'b1;
    ackDelay  = 0;
    ptrModel  = 0;
    outstanding = 1'b0;
    fork
      responder();
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_grant", 32'(reqGrant), 32'd0);
    check("rst_done", 32'(reqDone), 32'd0);
    check("rst_grant_id", 32'(grantId), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_req", 32'(outReq), 32'd0);
    check("rst_out_req_p1", 32'(outReq1), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Inverted reset phase: first token drives out_req 1->0, ack 0 completes it.
    reqValid1 = 4'b0001;
    @(negedge clk);
    check("p1_grant", 32'(reqGrant1), 32'd1);
    check("p1_grant_id", 32'(grantId1), 32'd0);
    reqValid1 = '0;
    @(negedge clk);
    check("p1_out_req", 32'(outReq1), 32'd0);
    repeat (2) @(negedge clk);
    outAck1 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (reqDone1 != '0) seen = 1'b1;
    end
    check("p1_done", 32'(reqDone1), 32'd1);
    @(negedge clk);
    check("p1_idle", 32'(busy1), 32'd0);
    check("p1_err", 32'(err1), 32'd0);

    // Single requester with exact grant / toggle timing.
    reqValid = 4'b0100;
    ackDelay = 4;
    modelRound(4'b0100);
    @(negedge clk);
    check("single_grant_e1", 32'(reqGrant), 32'h4);
    check("single_out_req_e1", 32'(outReq), 32'd0);
    reqValid = '0;
    @(negedge clk);
    check("single_out_req_e2", 32'(outReq), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    serve("single_serve", 50);

    // Fresh reset so contention starts from pointer 0.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    ptrModel = 0;
    @(negedge clk);

    // Contention: all four held for five grants -> 0,1,2,3,0.
    reqValid = 4'b1111;
    ackDelay = 1;
    for (int i = 0; i < 5; i++) begin
      expGrantQ.push_back(i % 4);
      expDoneQ.push_back(i % 4);
    end
    ptrModel = 1;
    grants = 0;
    for (int c = 0; c < 200 && grants < 5; c++) begin
      @(negedge clk);
      if (reqGrant != '0) grants++;
    end
    reqValid = '0;
    check("contention_grants", 32'(grants), 32'd5);
    serve("contention_serve", 100);

    // Synchronizer latency: done exactly after the third edge following the ack change.
    ackEnable = 1'b0;
    reqValid  = 4'b0010;
    modelRound(4'b0010);
    waitGrant("sync_grant");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 outAck = outReq;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      if (e < 3) check("sync_done_early", 32'(reqDone), 32'd0);
      else       check("sync_done", 32'(reqDone), 32'h2);
    end
    ackEnable = 1'b1;
    serve("sync_serve", 50);

    // Timeout: ack withheld, ERR after eight WAIT cycles, then clear and drain.
    ackEnable = 1'b0;
    reqValid  = 4'b1000;
    expGrantQ.push_back(3);
    waitGrant("to_grant");
    repeat (8) @(negedge clk);
    check("to_err_early", 32'(err), 32'd0);
    @(negedge clk);
    check("to_err_set", 32'(err), 32'd1);
    check("to_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check("to_err_sticky", 32'(err), 32'd1);
    check("to_no_grant", 32'(reqGrant), 32'd0);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    check("to_err_clr", 32'(err), 32'd0);
    check("to_drain_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check("to_drain_hold", 32'(busy), 32'd1);
    outAck = outReq;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check("to_drain_idle", 32'(seen), 32'd1);
    ackEnable = 1'b1;

    // Randomized rounds against the round-robin model.
    for (int r = 0; r < 12; r++) begin
      pattern  = 4'($urandom_range(1, 15));
      reqValid = pattern;
      modelRound(pattern);
      serve("rand_serve", 300);
    end

    // Asynchronous reset in the middle of WAIT.
    ackEnable = 1'b0;
    reqValid  = 4'b0100;
    expGrantQ.push_back(2);
    waitGrant("mid_rst_grant_seen");
    @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(reqGrant), 32'd0);
    check("mid_rst_done", 32'(reqDone), 32'd0);
    check("mid_rst_grant_id", 32'(grantId), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_out_req", 32'(outReq), 32'd0);
    expGrantQ.delete();
    expDoneQ.delete();
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    ptrModel  = 0;
    reqValid  = 4'b0001;
    modelRound(4'b0001);
    ackEnable = 1'b1;
    serve("post_rst_serve", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
